// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath among NREQ requesters, one op in flight.
// Optional: ADDER_ARB_BYPASS_EN lets a new grant issue in the same cycle a held result retires.
module adder_rr_arbiter #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_x,
  input  logic [NREQ*N-1:0] req_y,
  input  logic [NREQ-1:0]   req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [N-1:0]      rsp_s,
  output logic              rsp_c,
  output logic              rsp_o,
  output logic              rsp_z
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [N-1:0]  s;
    logic          c;
    logic          o;
    logic          z;
  } rsp_t;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  rsp_t          rsp_q, rsp_d;

  logic          grant_any_c;
  logic [IW-1:0] grant_idx_c;
  logic [IW-1:0] grant_nxt_c;
  logic          grant_en_c;
  logic          hs_c;
  logic [N-1:0]  x_c, y_c, t_c;
  logic          sel_c;
  logic [N:0]    sum_c;
  rsp_t          res_c;

  // First valid requester scanning ptr, ptr+1, ... modulo NREQ.
  always_comb begin
    logic [IW:0] idx;
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) begin
        idx = idx - (IW+1)'(NREQ);
      end
      if (!grant_any_c && req_valid[idx[IW-1:0]]) begin
        grant_any_c = 1'b1;
        grant_idx_c = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    grant_nxt_c = '0;
    if (grant_idx_c != IW'(NREQ - 1)) begin
      grant_nxt_c = grant_idx_c + IW'(1);
    end
  end

`ifdef ADDER_ARB_BYPASS_EN
  assign grant_en_c = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
`else
  assign grant_en_c = !rst && (state_q == IDLE);
`endif

  assign hs_c      = grant_en_c && grant_any_c;
  assign req_ready = hs_c ? (NREQ'(1) << grant_idx_c) : '0;

  // Shared datapath: subtraction as x + ~y + 1.
  assign x_c   = req_x[grant_idx_c*N +: N];
  assign y_c   = req_y[grant_idx_c*N +: N];
  assign sel_c = req_sel[grant_idx_c];
  assign t_c   = y_c ^ {N{sel_c}};
  assign sum_c = {1'b0, x_c} + {1'b0, t_c} + (N+1)'(sel_c);

  always_comb begin
    res_c    = '0;
    res_c.id = grant_idx_c;
    res_c.s  = sum_c[N-1:0];
    res_c.c  = sum_c[N];
    res_c.o  = ~(x_c[N-1] ^ t_c[N-1]) & (sum_c[N-1] ^ x_c[N-1]);
    res_c.z  = (sum_c[N-1:0] == '0);
  end

  // Next-state: retire on response handshake, load on grant handshake.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: state_d = IDLE;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (hs_c) begin
      rsp_d   = res_c;
      ptr_d   = grant_nxt_c;
      state_d = RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rsp_q   <= rsp_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_q.id;
  assign rsp_s     = rsp_q.s;
  assign rsp_c     = rsp_q.c;
  assign rsp_o     = rsp_q.o;
  assign rsp_z     = rsp_q.z;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomised and directed bench for adder_rr_arbiter against an arithmetic reference model.
module tb_adder_rr_arbiter;
  localparam int unsigned N    = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_sel;
  logic [NREQ*N-1:0] req_x, req_y;
  logic              rsp_valid, rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [N-1:0]      rsp_s;
  logic              rsp_c, rsp_o, rsp_z;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  bit m_busy  = 1'b0;
  bit m_known = 1'b0;
  int m_ptr   = 0;
  int m_id, m_s, m_c, m_o, m_z;

  always #5 clk = ~clk;

  adder_rr_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_c(rsp_c), .rsp_o(rsp_o), .rsp_z(rsp_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: check outputs at negedge, advance the model, land at posedge+1.
  task automatic step();
    bit allow, found;
    int g, x, y, sx, sy, r;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    allow = !rst && !m_busy;
`ifdef ADDER_ARB_BYPASS_EN
    allow = !rst && (!m_busy || rsp_ready);
`endif
    found = 1'b0;
    g = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(m_ptr + k) % NREQ]) begin
        found = 1'b1;
        g = (m_ptr + k) % NREQ;
      end
    end
    exp_ready = (allow && found) ? NREQ'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_busy));
    if (m_known) begin
      chk("rsp_id", 32'(rsp_id), m_id);
      chk("rsp_s",  32'(rsp_s),  m_s);
      chk("rsp_c",  32'(rsp_c),  m_c);
      chk("rsp_o",  32'(rsp_o),  m_o);
      chk("rsp_z",  32'(rsp_z),  m_z);
    end
    if (rst) begin
      m_busy = 1'b0; m_known = 1'b1; m_ptr = 0;
      m_id = 0; m_s = 0; m_c = 0; m_o = 0; m_z = 0;
    end else begin
      if (m_busy && rsp_ready) begin
        m_busy = 1'b0; m_known = 1'b0;
      end
      if (allow && found) begin
        x  = int'((req_x >> (g * N)) & 32'hFF);
        y  = int'((req_y >> (g * N)) & 32'hFF);
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        if (req_sel[g]) begin
          m_s = (x - y) & 255; m_c = (x >= y) ? 1 : 0; r = sx - sy;
        end else begin
          m_s = (x + y) & 255; m_c = (x + y > 255) ? 1 : 0; r = sx + sy;
        end
        m_o = (r > 127 || r < -128) ? 1 : 0;
        m_z = (m_s == 0) ? 1 : 0;
        m_id = g; m_busy = 1'b1; m_known = 1'b1;
        m_ptr = (g + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y, input logic sel);
    req_x[i*N +: N] = x;
    req_y[i*N +: N] = y;
    req_sel[i]      = sel;
  endtask

  initial begin
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    req_x = $urandom; req_y = $urandom; req_sel = '0;

    // 1: reset with all requests pending, then first grant goes to req0
    step(); step();
    rst = 1'b0;
    step();
    chk("t1_first_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    step(); step();

    // 2: single add on req1
    set_op(1, 8'h05, 8'h03, 1'b0);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    chk("t2_valid", 32'(rsp_valid), 32'd1);
    chk("t2_id", 32'(rsp_id), 32'd1);
    chk("t2_flags", {rsp_s, rsp_c, rsp_o, rsp_z}, {8'h08, 3'b000});
    step();

    // 3: subtractions on req2 with overflow and zero
    set_op(2, 8'h80, 8'h01, 1'b1);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    chk("t3a_flags", {rsp_s, rsp_c, rsp_o, rsp_z}, {8'h7F, 3'b110});
    step();
    set_op(2, 8'h3C, 8'h3C, 1'b1);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    chk("t3b_flags", {rsp_s, rsp_c, rsp_o, rsp_z}, {8'h00, 3'b101});
    step();

    // 4: all requesting, round-robin order from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = '1; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_x = $urandom; req_y = $urandom; req_sel = NREQ'($urandom);
      step();
      chk("t4_id", 32'(rsp_id), 32'(i % NREQ));
`ifndef ADDER_ARB_BYPASS_EN
      step();
`endif
    end

    // 5: consumer stalls, result must hold and no new grant
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_x = $urandom; req_y = $urandom;
      step();
    end
    rsp_ready = 1'b1;
    step(); step();

    // 6: reset while holding a result, pointer returns to req0
    req_valid = 4'b0010;
    step();
    rsp_ready = 1'b0; req_valid = '1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; rsp_ready = 1'b1;
    chk("t6_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("t6_id", 32'(rsp_id), 32'd0);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      req_valid = NREQ'($urandom);
      req_x     = $urandom;
      req_y     = $urandom;
      req_sel   = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
